// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC sequencer: FSM state encoding, MAC pipeline
// latency and the datapath widths used by the sequencer and its quantiser.
package mac_seq_pkg;

    localparam int MAC_LATENCY = 3;
    localparam int MAC_SUM_W   = 20;
    localparam int ACC_W       = 24;
    localparam int OUT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT,
        DONE
    } state_t;

    // Address ports never shrink below one bit, even for a single chunk/neuron.
    function automatic int addrWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_quant.sv
// Neuron accumulator and output quantiser: sums MAC results, shifts right by SHIFT
// and reduces to OUT_W bits. Define MAC_SEQ_SAT_EN to saturate instead of wrapping.
module mac_seq_quant
    import mac_seq_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_add,
    input  logic [MAC_SUM_W-1:0] i_sum,
    output logic [OUT_W-1:0]     o_q
);

    logic [ACC_W-1:0] r_acc;

    // Clear wins over add; the two never coincide because a neuron's first issue
    // only happens once the previous neuron's tags have all retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_sum);
        end
    end

`ifdef MAC_SEQ_SAT_EN
    logic [ACC_W-1:0] w_shifted;

    assign w_shifted = r_acc >> SHIFT;
    assign o_q       = (|(w_shifted >> OUT_W)) ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
`else
    assign o_q = OUT_W'(r_acc >> SHIFT);
`endif

endmodule

// File: rtl/mac_sequencer.sv
// Layer sequencer for a fixed-latency MAC: issues NUM_CHUNKS operand loads per neuron,
// drains the MAC pipeline and hands each quantised result over a valid/ready port.
// Output saturation is selected with the MAC_SEQ_SAT_EN macro (see mac_seq_quant).
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter  int NUM_CHUNKS  = 4,
    parameter  int NUM_NEURONS = 8,
    parameter  int SHIFT       = 8,
    localparam int CA_W        = addrWidth(NUM_CHUNKS),
    localparam int NA_W        = addrWidth(NUM_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mac_issue,
    output logic [CA_W-1:0]      chunk_addr,
    output logic [NA_W-1:0]      neuron_addr,
    input  logic [MAC_SUM_W-1:0] mac_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_W-1:0]     res_data,
    output logic [NA_W-1:0]      res_neuron
);

    localparam logic [CA_W-1:0] LAST_CHUNK  = CA_W'(NUM_CHUNKS - 1);
    localparam logic [NA_W-1:0] LAST_NEURON = NA_W'(NUM_NEURONS - 1);

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_macIssue;
    logic [CA_W-1:0]        r_chunkAddr;
    logic [NA_W-1:0]        r_neuronAddr;
    logic [MAC_LATENCY-1:0] r_tag;
    logic                   r_resValid;
    logic [OUT_W-1:0]       r_resData;
    logic [NA_W-1:0]        r_resNeuron;

    logic                   w_clear;
    logic                   w_add;
    logic [OUT_W-1:0]       w_quant;

    // A tag reaching the last stage marks the cycle its sum is present on mac_sum.
    assign w_clear = r_macIssue && (r_chunkAddr == '0);
    assign w_add   = r_tag[MAC_LATENCY-1];

    mac_seq_quant #(
        .SHIFT (SHIFT)
    ) u_quant (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_add   (w_add),
        .i_sum   (mac_sum),
        .o_q     (w_quant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_macIssue   <= 1'b0;
            r_chunkAddr  <= '0;
            r_neuronAddr <= '0;
            r_tag        <= '0;
            r_resValid   <= 1'b0;
            r_resData    <= '0;
            r_resNeuron  <= '0;
        end else begin
            r_tag  <= {r_tag[MAC_LATENCY-2:0], r_macIssue};
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= ISSUE;
                        r_busy       <= 1'b1;
                        r_macIssue   <= 1'b1;
                        r_chunkAddr  <= '0;
                        r_neuronAddr <= '0;
                    end
                end
                ISSUE: begin
                    if (r_chunkAddr == LAST_CHUNK) begin
                        r_macIssue  <= 1'b0;
                        r_chunkAddr <= '0;
                        r_state     <= DRAIN;
                    end else begin
                        r_chunkAddr <= r_chunkAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last sum was added at the previous edge, so the quantiser is final.
                    if (r_tag == '0) begin
                        r_state     <= OUTPUT;
                        r_resValid  <= 1'b1;
                        r_resData   <= w_quant;
                        r_resNeuron <= r_neuronAddr;
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        if (r_neuronAddr != LAST_NEURON) begin
                            r_neuronAddr <= r_neuronAddr + 1'b1;
                            r_macIssue   <= 1'b1;
                            r_state      <= ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_busy       <= 1'b0;
                    r_neuronAddr <= '0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mac_issue   = r_macIssue;
    assign chunk_addr  = r_chunkAddr;
    assign neuron_addr = r_neuronAddr;
    assign res_valid   = r_resValid;
    assign res_data    = r_resData;
    assign res_neuron  = r_resNeuron;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a 3-cycle MAC model feeds known chunk sums and
// each neuron result, handshake hold, mid-layer reset and ignored start are checked.
`timescale 1ns/1ps
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    localparam int NUM_CHUNKS  = 4;
    localparam int NUM_NEURONS = 8;
    localparam int SHIFT       = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        mac_issue;
    logic [1:0]  chunk_addr;
    logic [2:0]  neuron_addr;
    logic [19:0] mac_sum = '0;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [2:0]  res_neuron;

    logic [19:0] pipe1 = '0;
    logic [19:0] pipe2 = '0;

    int errors  = 0;
    int checks  = 0;
    int curMode = 0;

    always #5 clk = ~clk;

    mac_sequencer #(
        .NUM_CHUNKS  (NUM_CHUNKS),
        .NUM_NEURONS (NUM_NEURONS),
        .SHIFT       (SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mac_issue   (mac_issue),
        .chunk_addr  (chunk_addr),
        .neuron_addr (neuron_addr),
        .mac_sum     (mac_sum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_neuron  (res_neuron)
    );

    // Chunk sums: mode 0 = 16 ones scaled by 256 so SHIFT=8 yields 64 per neuron,
    // mode 1 = per-neuron/per-chunk ramp, mode 2 = all operands 255.
    function automatic logic [19:0] macModel(input int mode, input int n, input int c);
        case (mode)
            0:       return 20'd4096;
            1:       return 20'(((n * 8 + c + 1) << 8) + 63);
            default: return 20'd1040400;
        endcase
    endfunction

    // Hand-derived quantised results for the modes above.
    function automatic int expData(input int mode, input int n);
        case (mode)
            0: return 64;
            1: return 32 * n + 10;
            default: begin
`ifdef MAC_SEQ_SAT_EN
                return 255;
`else
                return 128;
`endif
            end
        endcase
    endfunction

    // Fixed-latency MAC: garbage whenever no operand load, so untagged sums are visible.
    always @(posedge clk) begin
        pipe1   <= mac_issue ? macModel(curMode, int'(neuron_addr), int'(chunk_addr)) : 20'hABCDE;
        pipe2   <= pipe1;
        mac_sum <= pipe2;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start     = s;
        res_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runLayer(input int mode, input int hold, input bit pokeStart);
        int cyc;
        int issues;
        int firstIssue;
        bit poked;
        curMode = mode;
        applyStimulus(1'b1, 1'b0);
        for (int n = 0; n < NUM_NEURONS; n++) begin
            cyc        = 0;
            issues     = 0;
            firstIssue = -1;
            poked      = 1'b0;
            while (!res_valid && cyc < 64) begin
                if (mac_issue) begin
                    if (firstIssue < 0) firstIssue = cyc;
                    checkOutput($sformatf("chunk_addr n%0d", n), int'(chunk_addr), issues);
                    checkOutput($sformatf("neuron_addr n%0d", n), int'(neuron_addr), n);
                    issues++;
                end
                if (pokeStart && !poked && issues == NUM_CHUNKS && !mac_issue) begin
                    poked = 1'b1;
                    applyStimulus(1'b1, 1'b0);
                end else begin
                    applyStimulus(1'b0, 1'b0);
                end
                cyc++;
            end
            checkOutput($sformatf("res_valid m%0d n%0d", mode, n), int'(res_valid), 1);
            checkOutput($sformatf("issue_count m%0d n%0d", mode, n), issues, NUM_CHUNKS);
            checkOutput($sformatf("first_issue m%0d n%0d", mode, n), firstIssue, 0);
            checkOutput($sformatf("issue_to_valid m%0d n%0d", mode, n), cyc - firstIssue, NUM_CHUNKS + 4);
            checkOutput($sformatf("res_data m%0d n%0d", mode, n), int'(res_data), expData(mode, n));
            checkOutput($sformatf("res_neuron m%0d n%0d", mode, n), int'(res_neuron), n);
            checkOutput($sformatf("busy_out m%0d n%0d", mode, n), int'(busy), 1);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(1'b0, 1'b0);
                checkOutput($sformatf("hold_valid n%0d h%0d", n, h), int'(res_valid), 1);
                checkOutput($sformatf("hold_data n%0d h%0d", n, h), int'(res_data), expData(mode, n));
                checkOutput($sformatf("hold_neuron n%0d h%0d", n, h), int'(res_neuron), n);
                checkOutput($sformatf("hold_issue n%0d h%0d", n, h), int'(mac_issue), 0);
            end
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("valid_drop n%0d", n), int'(res_valid), 0);
            if (n < NUM_NEURONS - 1) begin
                checkOutput($sformatf("done_mid n%0d", n), int'(done), 0);
            end
        end
        checkOutput($sformatf("done_pulse m%0d", mode), int'(done), 1);
        checkOutput($sformatf("busy_in_done m%0d", mode), int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("done_low m%0d c%0d", mode, i), int'(done), 0);
            checkOutput($sformatf("busy_idle m%0d c%0d", mode, i), int'(busy), 0);
            checkOutput($sformatf("issue_idle m%0d c%0d", mode, i), int'(mac_issue), 0);
        end
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_issue", int'(mac_issue), 0);
        checkOutput("rst_valid", int'(res_valid), 0);
        checkOutput("rst_data", int'(res_data), 0);
        checkOutput("rst_neuron", int'(res_neuron), 0);
        checkOutput("rst_chunk_addr", int'(chunk_addr), 0);
        checkOutput("rst_neuron_addr", int'(neuron_addr), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_no_start", int'(busy), 0);

        runLayer(0, 0, 1'b0);
        runLayer(1, 5, 1'b0);
        runLayer(2, 0, 1'b1);

        curMode = 1;
        applyStimulus(1'b1, 1'b1);
        w = 0;
        while (!(mac_issue && neuron_addr == 3'd2 && chunk_addr == 2'd1) && w < 200) begin
            applyStimulus(1'b0, 1'b1);
            w++;
        end
        checkOutput("reach_n2_issue", int'(w < 200), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_issue", int'(mac_issue), 0);
        checkOutput("midrst_valid", int'(res_valid), 0);
        checkOutput("midrst_data", int'(res_data), 0);
        checkOutput("midrst_neuron", int'(res_neuron), 0);
        checkOutput("midrst_chunk_addr", int'(chunk_addr), 0);
        checkOutput("midrst_neuron_addr", int'(neuron_addr), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("postrst_valid c%0d", i), int'(res_valid), 0);
            checkOutput($sformatf("postrst_busy c%0d", i), int'(busy), 0);
        end
        runLayer(1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter NUM_CHUNKS, default 4: 16-element chunks per neuron (power of two, 1..16) SHALL be supported.
REQ-002 Parameter NUM_NEURONS, default 8: neurons per layer (1..64) SHALL be supported.
REQ-003 Parameter SHIFT, default 8: right-shift applied to the accumulated sum before quantisation (0..15) SHALL be supported.
REQ-004 Clock and reset SHALL be: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-005 Port list SHALL be: clk in 1 clock; rst in 1 sync reset; start in 1 layer-start request; busy out 1 layer in progress; done out 1 one-cycle end-of-layer pulse.
REQ-006 Further ports SHALL be: mac_issue out 1 MAC operand load this cycle; chunk_addr out clog2(NUM_CHUNKS) chunk select; neuron_addr out clog2(NUM_NEURONS) weight-row select.
REQ-007 Further ports SHALL be: mac_sum in 20 MAC result; res_valid out 1; res_ready in 1; res_data out 8 quantised neuron output; res_neuron out clog2(NUM_NEURONS) neuron index of res_data.

Function
REQ-008 The MAC has fixed latency 3 and no stall: the sum for operands addressed in cycle t SHALL be sampled from mac_sum at the end of cycle t+3.
REQ-009 FSM states SHALL be IDLE, ISSUE, DRAIN, OUTPUT, DONE.
REQ-010 IDLE SHALL go to ISSUE on start=1; start SHALL be ignored in every other state.
REQ-011 ISSUE SHALL assert mac_issue for exactly NUM_CHUNKS consecutive cycles with chunk_addr 0..NUM_CHUNKS-1, then go to DRAIN.
REQ-012 A 3-stage valid-tag shift register SHALL track in-flight chunks; each tagged sum SHALL be added into a 24-bit accumulator that is cleared when the neuron's first chunk issues.
REQ-013 DRAIN SHALL go to OUTPUT in the cycle after the last tag retires; the result SHALL be registered into res_data/res_neuron and res_valid SHALL be set.
REQ-014 Quantisation SHALL be q = acc >> SHIFT, with res_data = q[7:0] (see REQ-022).
REQ-015 OUTPUT SHALL hold res_valid, res_data and res_neuron stable until res_ready=1.
REQ-016 On acceptance, if neuron_addr < NUM_NEURONS-1, the FSM SHALL increment neuron_addr and go to ISSUE; otherwise it SHALL go to DONE.
REQ-017 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE; no MAC issue SHALL occur while res_valid=1.
REQ-019 Accumulation SHALL be unsigned; the 24-bit width SHALL make overflow impossible for NUM_CHUNKS<=16.

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL enter IDLE and clear all outputs, tags, the accumulator, chunk_addr and neuron_addr to 0, in any state.
REQ-021 Sums still in the MAC pipeline after reset SHALL be discarded; no res_valid SHALL result from them.

Configuration
REQ-022 With macro MAC_SEQ_SAT_EN defined, res_data SHALL be 255 when q>255; without it, res_data SHALL be q[7:0] (wrap).

Structure
REQ-023 Package mac_seq_pkg SHALL hold the FSM state enum, MAC_LATENCY=3, MAC_SUM_W=20, ACC_W=24 and OUT_W=8.
REQ-024 Accumulate-and-quantise (accumulator, shift, saturate/wrap) SHALL be the sub-module mac_seq_quant; the FSM and tag pipe SHALL stay in mac_sequencer.

Verification
REQ-025 Defaults, pixels=1, weights=1, SHIFT=0 -> each chunk sum 16, all 8 outputs 64, res_neuron 0..7 in order, then done pulse.
REQ-026 All operands 255, SHIFT=8 -> acc=4161600, q=16256; SAT_EN gives res_data=255, no SAT_EN gives 128.
REQ-027 res_ready held low 5 cycles in OUTPUT -> res_data/res_neuron stable, mac_issue=0 throughout, next ISSUE starts the cycle after acceptance.
REQ-028 rst asserted during ISSUE of neuron 2 -> all outputs 0 next cycle, no res_valid over the following 10 cycles, fresh start restarts at neuron 0.
REQ-029 start pulsed during DRAIN -> ignored, exactly NUM_NEURONS results and a single done.
REQ-030 Check mac_issue pulses per neuron = NUM_CHUNKS and the gap from first issue to res_valid = NUM_CHUNKS+4 cycles.
